seg7_multi_display: RTL and testbench
=====================================

Name: seg7_multi_display

Overview:
- Parametrised multi-digit seven-segment display driver for the lab boards; successor to the single-digit 4-bit segment decoder.
- Accepts a DATA_W-bit binary value on a start pulse and renders it as hexadecimal or decimal across DIGITS active-low displays.
- Decimal mode uses a sequential double-dabble converter; the block also provides optional leading-zero blanking and overflow indication.
- Sits between datapath counters/registers and the board HEX pins.

Parameters:
- DATA_W, 16, width of the binary input value (4..32).
- DIGITS, 5, number of seven-segment displays driven (1..10).

Ports:
- Clock  in  1  system clock, all state on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  single-cycle request; captures Value/Mode/Blank_lz when idle.
- Value  in  DATA_W  binary value to display.
- Mode  in  1  0 = hexadecimal, 1 = decimal.
- Blank_lz  in  1  1 = blank leading zero digits.
- Busy  out  1  high while a conversion is in progress.
- Done  out  1  one-cycle pulse in the cycle HEX takes its new value.
- Ovf  out  1  value did not fit in DIGITS; held until the next update.
- HEX  out  7*DIGITS  active-low segments; digit k at bits [7k+6:7k]; bit0 = a ... bit6 = g.

Behaviour:
- Reset (synchronous, active-high):
  - HEX = all 1111111 (blank); Busy = 0; Done = 0; Ovf = 0; FSM to IDLE.
  - Reset asserted mid-conversion aborts it; the display goes blank.
- FSM states: IDLE, CONVERT, LOAD.
  - IDLE: on Start=1, register Value, Mode and Blank_lz; Busy=1 from the next cycle.
    - Mode=0 -> LOAD.
    - Mode=1 -> CONVERT with shift register = Value, BCD accumulator = 0, counter = 0.
  - CONVERT: one double-dabble step per cycle.
    - Each BCD nibble >= 5 gets +3.
    - Then shift {BCD, bin} left by 1.
    - After exactly DATA_W steps -> LOAD.
    - BCD accumulator width = 4*ceil(DATA_W*0.30103 + 1) nibbles, fixed in the package function.
  - LOAD: compute digits and update the HEX registers; Done=1 for this cycle only; Busy=0 next cycle; -> IDLE.
- Latency from the Start cycle edge to HEX/Done:
  - hex mode: 2 cycles.
  - decimal mode: DATA_W+2 cycles.
- Start while Busy=1 is ignored; it is not queued. Start and Reset in the same cycle: Reset wins.
- Start in the LOAD cycle is ignored; back-to-back requests therefore need one IDLE cycle.
- HEX holds its last value between updates; Value changes while busy have no effect.
- Hex digit k = Value[4k+3:4k], zero-extended beyond DATA_W.
- Decimal digit k = BCD nibble k.
- Segment codes, active-low, g..a:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
  - blank=1111111, dash=0111111
- Leading-zero blanking (Blank_lz=1): every zero digit above the most significant nonzero digit shows blank. Digit 0 is never blanked, so a value of 0 shows "0".
- Overflow: any nonzero digit/nibble at position >= DIGITS sets Ovf=1 and drives all displays to dash. Otherwise Ovf=0. Ovf is updated only in LOAD.

Decomposition:
- Package seg7_pkg holds:
  - segment constants SEG_0..SEG_F, SEG_BLANK, SEG_DASH;
  - the FSM state encoding;
  - a constant function giving the BCD nibble count for DATA_W.
- Sub-module seg7_digit: combinational 4-bit -> 7-bit active-low decoder with a blank input. It is instantiated DIGITS times from a generate loop.
- The FSM and double-dabble datapath stay in the top module.

Test Plan:
- Reset: assert Reset for 2 cycles mid-conversion of 12345 -> HEX = all 1111111, Busy=0, Done=0, Ovf=0 on the next edge. No Done follows.
- Hex mode (DATA_W=16, DIGITS=5): Start with Value=16'hBEEF, Mode=0, Blank_lz=0 -> 2 cycles later Done=1.
  - digits4..0 = 1000000, 0000011, 0000110, 0000110, 0001110.
  - Ovf=0.
- Decimal full-scale: Value=65535, Mode=1 -> Done exactly 18 cycles after Start; Busy high for cycles 1..17.
  - digits4..0 = 6,5,5,3,5 = 0000010, 0010010, 0010010, 0110000, 0010010.
- Leading-zero blanking: Value=42, Mode=1, Blank_lz=1 -> digits4..2 = 1111111, digit1 = 0011001, digit0 = 0100100.
  - Value=0 with Blank_lz=1 -> digit0 = 1000000, the others blank.
- Overflow (DIGITS=3):
  - Value=1000, Mode=1 -> all three digits 0111111, Ovf=1.
  - Then Value=999 -> 9,9,9 with Ovf=0.
  - Hex Value=16'h1000 -> dashes, Ovf=1.
- Start while busy: second Start with 7 issued 3 cycles into a conversion of 65535 -> ignored; display shows 65535 and only one Done pulse.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the multi-digit seven-segment driver:
// active-low segment codes, FSM states and BCD sizing.
package seg7_pkg;

    // Active-low segments, bit order g..a.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONVERT,
        S_LOAD
    } state_e;

    // ceil(w*log10(2) + 1) in fixed point; w*30103 is never an exact
    // multiple of 100000 for the supported widths, so the +99999 rounds up.
    function automatic int unsigned bcd_nibbles(input int unsigned w);
        return (w * 30103 + 99999) / 100000 + 1;
    endfunction

endpackage

// File: rtl/seg7_digit.sv
// Combinational 4-bit to active-low seven-segment decoder with blanking.
module seg7_digit
    import seg7_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (!blank_i) begin
            case (digit_i)
                4'h0: seg_o = SEG_0;
                4'h1: seg_o = SEG_1;
                4'h2: seg_o = SEG_2;
                4'h3: seg_o = SEG_3;
                4'h4: seg_o = SEG_4;
                4'h5: seg_o = SEG_5;
                4'h6: seg_o = SEG_6;
                4'h7: seg_o = SEG_7;
                4'h8: seg_o = SEG_8;
                4'h9: seg_o = SEG_9;
                4'hA: seg_o = SEG_A;
                4'hB: seg_o = SEG_B;
                4'hC: seg_o = SEG_C;
                4'hD: seg_o = SEG_D;
                4'hE: seg_o = SEG_E;
                4'hF: seg_o = SEG_F;
            endcase
        end
    end

endmodule

// File: rtl/seg7_multi_display.sv
// Multi-digit hex/decimal seven-segment driver with a sequential
// double-dabble converter, leading-zero blanking and overflow dashes.
module seg7_multi_display
    import seg7_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DIGITS = 5
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [DATA_W-1:0]     Value,
    input  logic                  Mode,
    input  logic                  Blank_lz,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Ovf,
    output logic [7*DIGITS-1:0]   HEX
);

    localparam int unsigned NIB   = bcd_nibbles(DATA_W);
    localparam int unsigned BCD_W = 4 * NIB;
    localparam int unsigned NALL  = (DIGITS > NIB) ? DIGITS : NIB;
    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                mode_q, mode_d;
    logic                blank_q, blank_d;
    logic [7*DIGITS-1:0] hex_q, hex_d;
    logic                done_q, done_d;
    logic                ovf_q, ovf_d;

    logic [4*NALL-1:0]   src;
    logic [BCD_W-1:0]    bcd_adj;
    logic [DIGITS-1:0]   blank_dig;
    logic [7*DIGITS-1:0] seg;
    logic                ovf_c;

    // Digit source: raw binary nibbles in hex mode, BCD nibbles in decimal mode.
    always_comb begin
        src = '0;
        if (mode_q) src[BCD_W-1:0] = bcd_q;
        else        src[DATA_W-1:0] = bin_q;
    end

    always_comb begin
        ovf_c = 1'b0;
        for (int unsigned k = DIGITS; k < NALL; k++)
            if (src[4*k +: 4] != 4'd0) ovf_c = 1'b1;
    end

    always_comb begin
        logic seen_nz;
        seen_nz   = 1'b0;
        blank_dig = '0;
        for (int unsigned k = DIGITS - 1; k >= 1; k--) begin
            if (src[4*k +: 4] != 4'd0) seen_nz = 1'b1;
            blank_dig[k] = blank_q && !seen_nz;
        end
    end

    for (genvar k = 0; k < DIGITS; k++) begin : g_dig
        seg7_digit u_digit (
            .digit_i (src[4*k +: 4]),
            .blank_i (blank_dig[k]),
            .seg_o   (seg[7*k +: 7])
        );
    end

    always_comb begin
        bcd_adj = bcd_q;
        for (int unsigned k = 0; k < NIB; k++)
            if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        blank_d = blank_q;
        hex_d   = hex_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (Start) begin
                    bin_d   = Value;
                    mode_d  = Mode;
                    blank_d = Blank_lz;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = Mode ? S_CONVERT : S_LOAD;
                end
            end
            S_CONVERT: begin
                {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DATA_W - 1)) state_d = S_LOAD;
            end
            S_LOAD: begin
                hex_d   = ovf_c ? {DIGITS{SEG_DASH}} : seg;
                ovf_d   = ovf_c;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= S_IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            blank_q <= 1'b0;
            hex_q   <= '1;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            blank_q <= blank_d;
            hex_q   <= hex_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    assign Busy = (state_q != S_IDLE);
    assign Done = done_q;
    assign Ovf  = ovf_q;
    assign HEX  = hex_q;

endmodule

// File: tb/tb_seg7_multi_display.sv
// Bench for seg7_multi_display: a 5-digit and a 3-digit instance share the
// same stimulus and are checked against an arithmetic digit model.
module tb_seg7_multi_display;

    logic        clk = 1'b0;
    logic        rst, start, mode, blank;
    logic [15:0] value;
    logic        busy5, done5, ovf5;
    logic [34:0] hex5;
    logic        busy3, done3, ovf3;
    logic [20:0] hex3;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [6:0] segtab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    always #5 clk = ~clk;

    seg7_multi_display #(.DATA_W(16), .DIGITS(5)) dut5 (
        .Clock(clk), .Reset(rst), .Start(start), .Value(value), .Mode(mode),
        .Blank_lz(blank), .Busy(busy5), .Done(done5), .Ovf(ovf5), .HEX(hex5)
    );

    seg7_multi_display #(.DATA_W(16), .DIGITS(3)) dut3 (
        .Clock(clk), .Reset(rst), .Start(start), .Value(value), .Mode(mode),
        .Blank_lz(blank), .Busy(busy3), .Done(done3), .Ovf(ovf3), .HEX(hex3)
    );

    // Digit k = floor(v / radix^k) mod radix; blank when v < radix^k.
    function automatic logic [34:0] model_hex(input int unsigned v, input bit m,
                                              input bit b, input int nd);
        longint unsigned radix, p, lim, d, vv;
        logic [34:0] r;
        vv    = 64'(v);
        radix = m ? 64'd10 : 64'd16;
        r     = '1;
        lim   = 1;
        for (int k = 0; k < nd; k++) lim = lim * radix;
        p = 1;
        for (int k = 0; k < nd; k++) begin
            d = (vv / p) % radix;
            if (vv >= lim)                  r[7*k +: 7] = 7'b0111111;
            else if (b && k > 0 && vv < p)  r[7*k +: 7] = 7'b1111111;
            else                            r[7*k +: 7] = segtab[d[3:0]];
            p = p * radix;
        end
        return r;
    endfunction

    function automatic bit model_ovf(input int unsigned v, input bit m, input int nd);
        longint unsigned lim;
        lim = 1;
        for (int k = 0; k < nd; k++) lim = lim * (m ? 64'd10 : 64'd16);
        return 64'(v) >= lim;
    endfunction

    // Issues one request and waits (bounded) for Done on the 5-digit unit;
    // lat is the cycle index of Done after the Start cycle, -1 on timeout.
    task automatic do_txn(input int unsigned v, input bit m, input bit b,
                          output int lat, output int busy_err, output bit d3);
        @(negedge clk);
        value = 16'(v); mode = m; blank = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = -1; busy_err = 0; d3 = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (done5) begin
                lat = c;
                d3  = done3;
                if (busy5) busy_err++;
                break;
            end
            if (!busy5) busy_err++;
            value = 16'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int lat, be, dones;
        bit d3;
        rst = 1'b1; start = 1'b0; value = '0; mode = 1'b0; blank = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (hex5 !== '1) begin n_fail++; $display("FAIL reset_hex5: got %b expected all ones", hex5); end
        n_cmp++; if ({busy5, done5, ovf5} !== 3'b000) begin n_fail++; $display("FAIL reset_flags5: got %b expected 000", {busy5, done5, ovf5}); end
        n_cmp++; if (hex3 !== '1) begin n_fail++; $display("FAIL reset_hex3: got %b expected all ones", hex3); end

        do_txn(32'h1234, 1'b0, 1'b0, lat, be, d3);
        @(negedge clk);
        value = 16'd12345; mode = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (hex5 !== '1) begin n_fail++; $display("FAIL midreset_hex5: got %b expected all ones", hex5); end
        n_cmp++; if ({busy5, done5, ovf5} !== 3'b000) begin n_fail++; $display("FAIL midreset_flags5: got %b expected 000", {busy5, done5, ovf5}); end
        n_cmp++; if ({busy3, done3, ovf3} !== 3'b000) begin n_fail++; $display("FAIL midreset_flags3: got %b expected 000", {busy3, done3, ovf3}); end
        n_cmp++; if (hex3 !== '1) begin n_fail++; $display("FAIL midreset_hex3: got %b expected all ones", hex3); end
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        repeat (30) begin
            @(negedge clk);
            if (done5 || done3) dones++;
        end
        n_cmp++; if (dones !== 0) begin n_fail++; $display("FAIL midreset_no_done: got %0d expected 0", dones); end
        n_cmp++; if (hex5 !== '1) begin n_fail++; $display("FAIL midreset_hold: got %b expected all ones", hex5); end
    endtask

    task automatic test_hex();
        int lat, be;
        bit d3;
        do_txn(32'hBEEF, 1'b0, 1'b0, lat, be, d3);
        n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL hex_latency: got %0d expected 2", lat); end
        n_cmp++; if (be !== 0) begin n_fail++; $display("FAIL hex_busy: got %0d errors expected 0", be); end
        n_cmp++; if (hex5 !== {7'b1000000, 7'b0000011, 7'b0000110, 7'b0000110, 7'b0001110})
            begin n_fail++; $display("FAIL hex_beef: got %b expected BEEF pattern", hex5); end
        n_cmp++; if (ovf5 !== 1'b0) begin n_fail++; $display("FAIL hex_ovf5: got %b expected 0", ovf5); end
        n_cmp++; if (d3 !== 1'b1) begin n_fail++; $display("FAIL hex_done3: got %b expected 1", d3); end
        n_cmp++; if (hex3 !== {3{7'b0111111}}) begin n_fail++; $display("FAIL hex_dash3: got %b expected dashes", hex3); end
        n_cmp++; if (ovf3 !== 1'b1) begin n_fail++; $display("FAIL hex_ovf3: got %b expected 1", ovf3); end
    endtask

    task automatic test_decimal_full();
        int lat, be;
        bit d3;
        do_txn(65535, 1'b1, 1'b0, lat, be, d3);
        n_cmp++; if (lat !== 18) begin n_fail++; $display("FAIL dec_latency: got %0d expected 18", lat); end
        n_cmp++; if (be !== 0) begin n_fail++; $display("FAIL dec_busy: got %0d errors expected 0", be); end
        n_cmp++; if (hex5 !== {7'b0000010, 7'b0010010, 7'b0010010, 7'b0110000, 7'b0010010})
            begin n_fail++; $display("FAIL dec_65535: got %b expected 65535 pattern", hex5); end
        n_cmp++; if (ovf5 !== 1'b0) begin n_fail++; $display("FAIL dec_ovf5: got %b expected 0", ovf5); end
        n_cmp++; if (ovf3 !== 1'b1) begin n_fail++; $display("FAIL dec_ovf3: got %b expected 1", ovf3); end
    endtask

    task automatic test_blank();
        int lat, be;
        bit d3;
        logic [34:0] e;
        do_txn(42, 1'b1, 1'b1, lat, be, d3);
        n_cmp++; if (hex5 !== {7'b1111111, 7'b1111111, 7'b1111111, 7'b0011001, 7'b0100100})
            begin n_fail++; $display("FAIL blank_42: got %b expected __ _42", hex5); end
        e = model_hex(42, 1'b1, 1'b1, 3);
        n_cmp++; if (hex3 !== e[20:0]) begin n_fail++; $display("FAIL blank_42_d3: got %b expected %b", hex3, e[20:0]); end
        do_txn(0, 1'b1, 1'b1, lat, be, d3);
        n_cmp++; if (hex5 !== {{4{7'b1111111}}, 7'b1000000})
            begin n_fail++; $display("FAIL blank_zero: got %b expected ____0", hex5); end
        do_txn(32'h00A0, 1'b0, 1'b1, lat, be, d3);
        n_cmp++; if (hex5 !== {{3{7'b1111111}}, 7'b0001000, 7'b1000000})
            begin n_fail++; $display("FAIL blank_hex_a0: got %b expected ___A0", hex5); end
    endtask

    task automatic test_overflow();
        int lat, be;
        bit d3;
        do_txn(1000, 1'b1, 1'b0, lat, be, d3);
        n_cmp++; if (hex3 !== {3{7'b0111111}}) begin n_fail++; $display("FAIL ovf_1000: got %b expected dashes", hex3); end
        n_cmp++; if (ovf3 !== 1'b1) begin n_fail++; $display("FAIL ovf_1000_flag: got %b expected 1", ovf3); end
        n_cmp++; if (hex5 !== model_hex(1000, 1'b1, 1'b0, 5)) begin n_fail++; $display("FAIL ovf_1000_d5: got %b expected %b", hex5, model_hex(1000, 1'b1, 1'b0, 5)); end
        do_txn(999, 1'b1, 1'b0, lat, be, d3);
        n_cmp++; if (hex3 !== {3{7'b0010000}}) begin n_fail++; $display("FAIL ovf_999: got %b expected 999", hex3); end
        n_cmp++; if (ovf3 !== 1'b0) begin n_fail++; $display("FAIL ovf_999_flag: got %b expected 0", ovf3); end
        do_txn(32'h1000, 1'b0, 1'b0, lat, be, d3);
        n_cmp++; if (hex3 !== {3{7'b0111111}}) begin n_fail++; $display("FAIL ovf_h1000: got %b expected dashes", hex3); end
        n_cmp++; if (ovf3 !== 1'b1) begin n_fail++; $display("FAIL ovf_h1000_flag: got %b expected 1", ovf3); end
        do_txn(32'h0FFF, 1'b0, 1'b0, lat, be, d3);
        n_cmp++; if (ovf3 !== 1'b0) begin n_fail++; $display("FAIL ovf_h0fff_flag: got %b expected 0", ovf3); end
    endtask

    task automatic test_start_busy();
        int dones, lat;
        @(negedge clk);
        value = 16'd65535; mode = 1'b1; blank = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dones = 0; lat = -1;
        for (int c = 1; c <= 40; c++) begin
            if (done5) begin
                dones++;
                if (lat < 0) lat = c;
            end
            start = (c == 3);
            value = (c == 3) ? 16'd7 : 16'($urandom);
            mode  = (c == 3) ? 1'b0 : 1'b1;
            @(negedge clk);
        end
        n_cmp++; if (dones !== 1) begin n_fail++; $display("FAIL busy_start_dones: got %0d expected 1", dones); end
        n_cmp++; if (lat !== 18) begin n_fail++; $display("FAIL busy_start_latency: got %0d expected 18", lat); end
        n_cmp++; if (hex5 !== model_hex(65535, 1'b1, 1'b0, 5)) begin n_fail++; $display("FAIL busy_start_hex: got %b expected %b", hex5, model_hex(65535, 1'b1, 1'b0, 5)); end
    endtask

    task automatic test_back_to_back();
        int unsigned v1, v2, v3;
        int bad;
        v1 = $urandom_range(0, 65535);
        v2 = $urandom_range(0, 65535);
        v3 = $urandom_range(0, 65535);
        bad = 0;
        @(negedge clk);
        value = 16'(v1); mode = 1'b0; blank = 1'b0; start = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= 10; c++) begin
            if (done5) begin
                if (c == 2) begin
                    n_cmp++; if (hex5 !== model_hex(v1, 1'b0, 1'b0, 5)) begin n_fail++; $display("FAIL b2b_first: got %b expected %b", hex5, model_hex(v1, 1'b0, 1'b0, 5)); end
                end else if (c == 4) begin
                    n_cmp++; if (hex5 !== model_hex(v3, 1'b0, 1'b0, 5)) begin n_fail++; $display("FAIL b2b_second: got %b expected %b", hex5, model_hex(v3, 1'b0, 1'b0, 5)); end
                end else bad++;
            end else if (c == 2 || c == 4) bad++;
            start = (c == 1 || c == 2);
            value = (c == 1) ? 16'(v2) : 16'(v3);
            @(negedge clk);
        end
        start = 1'b0;
        n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL b2b_done_timing: got %0d bad cycles expected 0", bad); end
    endtask

    task automatic test_random();
        int lat, be;
        bit d3, m, b;
        int unsigned v;
        logic [34:0] e5, e3;
        for (int i = 0; i < 40; i++) begin
            v = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1500) : $urandom_range(0, 65535);
            m = 1'($urandom);
            b = 1'($urandom);
            do_txn(v, m, b, lat, be, d3);
            e5 = model_hex(v, m, b, 5);
            e3 = model_hex(v, m, b, 3);
            n_cmp++; if (lat !== (m ? 18 : 2)) begin n_fail++; $display("FAIL rnd_latency v=%0d m=%0d: got %0d expected %0d", v, m, lat, m ? 18 : 2); end
            n_cmp++; if (be !== 0 || d3 !== 1'b1) begin n_fail++; $display("FAIL rnd_busy_done v=%0d: got busy_err=%0d done3=%b expected 0/1", v, be, d3); end
            n_cmp++; if (hex5 !== e5) begin n_fail++; $display("FAIL rnd_hex5 v=%0d m=%0d b=%0d: got %b expected %b", v, m, b, hex5, e5); end
            n_cmp++; if (hex3 !== e3[20:0]) begin n_fail++; $display("FAIL rnd_hex3 v=%0d m=%0d b=%0d: got %b expected %b", v, m, b, hex3, e3[20:0]); end
            n_cmp++; if ({ovf5, ovf3} !== {model_ovf(v, m, 5), model_ovf(v, m, 3)})
                begin n_fail++; $display("FAIL rnd_ovf v=%0d m=%0d: got %b%b expected %b%b", v, m, ovf5, ovf3, model_ovf(v, m, 5), model_ovf(v, m, 3)); end
        end
    endtask

    initial begin
        test_reset();
        test_hex();
        test_decimal_full();
        test_blank();
        test_overflow();
        test_start_busy();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
